// File: rtl/spi_cfg_pkg.sv
// Shared widths, register map and FSM encoding for the SPI config master.
// The frame layout struct matches the on-wire bit order, MSB first.
package spi_cfg_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_cfg_master_if.sv
// Request/status bundle between a configuration client (master modport)
// and the SPI config controller (slave modport).
interface spi_cfg_master_if import spi_cfg_pkg::*; ();

  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              abort;
  logic              busy;
  logic              done;
  logic              aborted;

  modport master (
    output req_valid, req_rw, req_addr, req_data, abort,
    input  req_ready, busy, done, aborted
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, abort,
    output req_ready, busy, done, aborted
  );

endinterface

// File: rtl/spi_cfg_master_phase_timer.sv
// Loadable down-counter that saturates at zero; tc_o flags the last cycle
// of a delay loaded as (length - 1).
module spi_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/spi_cfg_master.sv
// SPI mode-0 config-write master: one 16-bit {rw, addr, data} frame per
// request, with registered nCS/sCLK/COPI and abort support.
module spi_cfg_master import spi_cfg_pkg::*; #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_cfg_master_if.slave   req,
  output logic              ncs_o,
  output logic              sclk_o,
  output logic              copi_o
);

  localparam int PHASE_W = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP) + 1);
  localparam logic [PHASE_W-1:0] LD_DIV   = PHASE_W'(CLK_DIV - 1);
  localparam logic [PHASE_W-1:0] LD_SETUP = PHASE_W'(CS_SETUP - 1);
  localparam logic [PHASE_W-1:0] LD_HOLD  = PHASE_W'(CS_HOLD - 1);
  localparam logic [PHASE_W-1:0] LD_GAP   = PHASE_W'(CS_GAP - 1);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic               ncs_q, ncs_d, sclk_q, sclk_d, copi_q, copi_d;
  logic               ready_q, ready_d, busy_q, busy_d;
  logic               done_q, done_d, aborted_q, aborted_d;

  logic               tmr_load, tmr_tc;
  logic [PHASE_W-1:0] tmr_val;
  logic               hs, abort_hit, last_bit;
  frame_t             req_frame;

  assign req_frame = '{rw: req.req_rw, addr: req.req_addr, data: req.req_data};
  assign hs        = req.req_valid && ready_q;
  assign abort_hit = req.abort && (state_q == ST_SETUP || state_q == ST_SHIFT);
  assign last_bit  = (bit_cnt_q == 4'd15);

  spi_phase_timer #(.W(PHASE_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (hs) state_d = ST_SETUP;
      ST_SETUP: if (abort_hit) state_d = ST_GAP;
                else if (tmr_tc) state_d = ST_SHIFT;
      ST_SHIFT: if (abort_hit) state_d = ST_GAP;
                else if (tmr_tc && sclk_q && last_bit) state_d = ST_HOLD;
      ST_HOLD:  if (tmr_tc) state_d = ST_GAP;
      ST_GAP:   if (tmr_tc) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ncs_d     = ncs_q;
    sclk_d    = sclk_q;
    copi_d    = copi_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    ready_d   = (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: if (hs) begin
        shift_d   = req_frame;
        bit_cnt_d = '0;
        ncs_d     = 1'b0;
        copi_d    = req_frame[FRAME_W-1];
        tmr_load  = 1'b1;
        tmr_val   = LD_SETUP;
      end
      ST_SETUP, ST_SHIFT: begin
        if (abort_hit) begin
          // Abort wins over a pending rise, so a cancelled edge never reaches the pin.
          ncs_d     = 1'b1;
          sclk_d    = 1'b0;
          aborted_d = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = LD_GAP;
        end else if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = LD_DIV;
          if (state_q == ST_SHIFT) begin
            sclk_d = ~sclk_q;
            if (sclk_q) begin
              if (last_bit) begin
                tmr_val = LD_HOLD;
              end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = shift_q << 1;
                copi_d    = shift_q[FRAME_W-2];
              end
            end
          end
        end
      end
      ST_HOLD: if (tmr_tc) begin
        ncs_d    = 1'b1;
        done_d   = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = LD_GAP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ncs_q     <= 1'b1;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ncs_q     <= ncs_d;
      sclk_q    <= sclk_d;
      copi_q    <= copi_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign req.req_ready = ready_q;
  assign req.busy      = busy_q;
  assign req.done      = done_q;
  assign req.aborted   = aborted_q;
  assign ncs_o         = ncs_q;
  assign sclk_o        = sclk_q;
  assign copi_o        = copi_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: a behavioural SPI register-bank peripheral plus
// waveform monitors; directed frame table followed by multi-cycle corner cases.
module tb_spi_cfg_master;
  import spi_cfg_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_GAP   = 8;
  localparam int LAT      = 1 + CS_SETUP + 32 * CLK_DIV + CS_HOLD;
  localparam int NCS_LOW  = CS_SETUP + 32 * CLK_DIV + CS_HOLD;
  localparam int ABORT_IN_HOLD = 17;
  localparam int ABORT_AT_HS   = 18;

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  data;
    int          abort_mode;
    logic [15:0] exp_rx;
    int          exp_rises;
    bit          exp_done;
    int          chk_addr;
    logic [7:0]  exp_reg;
  } vec_t;

  typedef struct {
    int          rises;
    int          ncs_low;
    int          n_done;
    int          n_abort;
    int          evt_cyc;
    int          abort_cyc;
    int          gap;
    logic        ncs_at_evt;
    logic [15:0] rx;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ncs, sclk, copi;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  spi_cfg_master_if bus ();

  spi_cfg_master #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.slave),
    .ncs_o (ncs),
    .sclk_o(sclk),
    .copi_o(copi)
  );

  // Peripheral register bank: shifts on sCLK rise, commits only a full write frame.
  logic [7:0]  regs [0:4];
  logic [15:0] rx_sh = '0;
  int          nrise = 0;

  initial for (int i = 0; i < 5; i++) regs[i] = 8'h00;

  always @(negedge ncs) begin
    nrise = 0;
    rx_sh = '0;
  end

  always @(posedge sclk) if (!ncs) begin
    rx_sh = {rx_sh[14:0], copi};
    nrise++;
  end

  always @(posedge ncs) begin : commit
    int a;
    a = int'(rx_sh[14:8]);
    if (nrise == 16 && rx_sh[15] && a <= 4) regs[a] = rx_sh[7:0];
  end

  // Waveform rules: copi moves only on an sclk fall or frame start, sclk idles
  // low while deselected, and done/aborted never overlap.
  logic p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0;
  int   wave_err = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ncs && sclk) wave_err++;
      if (!ncs && !p_ncs && copi != p_copi && !(p_sclk && !sclk)) wave_err++;
      if (bus.done && bus.aborted) wave_err++;
    end
    p_ncs  = ncs;
    p_sclk = sclk;
    p_copi = copi;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left on a falling edge; cycle k is the k-th cycle after the handshake edge.
  task automatic run_frame(input vec_t v, output res_t r);
    int   guard;
    logic prev_sclk, rose;
    r = '{default: 0};
    bus.req_rw    = v.rw;
    bus.req_addr  = v.addr;
    bus.req_data  = v.data;
    bus.req_valid = 1'b1;
    bus.abort     = (v.abort_mode == ABORT_AT_HS);
    guard = 0;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    prev_sclk = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      bus.req_valid = 1'b0;
      bus.abort     = 1'b0;
      rose      = sclk && !prev_sclk;
      prev_sclk = sclk;
      if (rose) r.rises++;
      if (!ncs) r.ncs_low++;
      if (bus.done)    begin r.n_done++;  r.evt_cyc = k; r.ncs_at_evt = ncs; end
      if (bus.aborted) begin r.n_abort++; r.evt_cyc = k; r.ncs_at_evt = ncs; end
      if (r.evt_cyc != 0 && bus.req_ready) begin
        r.gap = k - r.evt_cyc;
        break;
      end
      if (r.evt_cyc == 0 && r.abort_cyc == 0 &&
          ((rose && r.rises == v.abort_mode) ||
           (v.abort_mode == ABORT_IN_HOLD && r.rises == 16 && !sclk))) begin
        bus.abort   = 1'b1;
        r.abort_cyc = k;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.abort     = 1'b0;
    r.rx = rx_sh;
  endtask

  vec_t vecs [7];
  res_t r;
  int   t_rise, t_fall, got, rcnt;
  logic prev_s;

  initial begin
    vecs[0] = '{1'b1, ADDR_EN_OUT_LO, 8'hA5, 0,             16'h80A5, 16, 1'b1, 0, 8'hA5};
    vecs[1] = '{1'b0, ADDR_EN_OUT_HI, 8'h3C, 0,             16'h013C, 16, 1'b1, 1, 8'h00};
    vecs[2] = '{1'b1, 7'h7F,          8'h11, 0,             16'hFF11, 16, 1'b1, 0, 8'hA5};
    vecs[3] = '{1'b1, ADDR_EN_OUT_HI, 8'hC3, 9,             16'h0103,  9, 1'b0, 1, 8'h00};
    vecs[4] = '{1'b1, ADDR_EN_PWM_HI, 8'h5A, 0,             16'h835A, 16, 1'b1, 3, 8'h5A};
    vecs[5] = '{1'b1, ADDR_EN_OUT_LO, 8'h66, ABORT_IN_HOLD, 16'h8066, 16, 1'b1, 0, 8'h66};
    vecs[6] = '{1'b1, ADDR_EN_PWM_LO, 8'h0F, ABORT_AT_HS,   16'h820F, 16, 1'b1, 2, 8'h0F};

    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.abort     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",   bus.req_ready, 0);
    check("rst_busy",    bus.busy, 0);
    check("rst_done",    bus.done, 0);
    check("rst_aborted", bus.aborted, 0);
    check("rst_ncs",     ncs, 1);
    check("rst_sclk",    sclk, 0);
    check("rst_copi",    copi, 0);
    rst_n = 1'b1;
    #1 check("rel_ready_before_edge", bus.req_ready, 0);
    @(negedge clk);
    check("rel_ready_after_edge", bus.req_ready, 1);

    // Abort while idle must be ignored.
    bus.abort = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_abort_busy",    bus.busy, 0);
    check("idle_abort_aborted", bus.aborted, 0);
    check("idle_abort_ready",   bus.req_ready, 1);
    bus.abort = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], r);
      check($sformatf("v%0d_rises", i), r.rises, vecs[i].exp_rises);
      check($sformatf("v%0d_rx", i), r.rx, vecs[i].exp_rx);
      check($sformatf("v%0d_ncs_at_end", i), r.ncs_at_evt, 1);
      check($sformatf("v%0d_gap", i), r.gap, CS_GAP);
      if (vecs[i].exp_done) begin
        check($sformatf("v%0d_done_cnt", i), r.n_done, 1);
        check($sformatf("v%0d_abort_cnt", i), r.n_abort, 0);
        check($sformatf("v%0d_latency", i), r.evt_cyc, LAT);
        check($sformatf("v%0d_ncs_low", i), r.ncs_low, NCS_LOW);
      end else begin
        check($sformatf("v%0d_done_cnt", i), r.n_done, 0);
        check($sformatf("v%0d_abort_cnt", i), r.n_abort, 1);
        check($sformatf("v%0d_abort_delay", i), r.evt_cyc - r.abort_cyc, 1);
      end
      check($sformatf("v%0d_reg", i), regs[vecs[i].chk_addr], vecs[i].exp_reg);
    end

    // Back-to-back writes with req_valid held across the gap.
    bus.req_rw    = 1'b1;
    bus.req_addr  = ADDR_PWM_DUTY;
    bus.req_data  = 8'h80;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_addr = ADDR_EN_PWM_LO;
    bus.req_data = 8'hFF;
    t_rise = 0;
    t_fall = 0;
    for (int k = 1; k <= 400 && t_fall == 0; k++) begin
      if (t_rise == 0) begin
        if (bus.done) t_rise = k;
      end else if (!ncs) begin
        t_fall = k;
      end
      if (t_fall == 0) @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b_first_done_seen", t_rise != 0, 1);
    check("b2b_gap_min", (t_fall - t_rise) >= CS_GAP + 1, 1);
    got = 0;
    for (int k = 0; k < 400; k++) begin
      if (bus.done) got++;
      if (got != 0 && bus.req_ready) break;
      @(negedge clk);
    end
    check("b2b_second_done", got, 1);
    check("b2b_reg_duty", regs[4], 8'h80);
    check("b2b_reg_pwm_lo", regs[2], 8'hFF);

    // Asynchronous reset in the middle of a write frame.
    bus.req_rw    = 1'b1;
    bus.req_addr  = ADDR_EN_OUT_LO;
    bus.req_data  = 8'h3C;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rcnt   = 0;
    prev_s = 1'b0;
    for (int k = 0; k < 300 && rcnt < 8; k++) begin
      if (sclk && !prev_s) rcnt++;
      prev_s = sclk;
      if (rcnt < 8) @(negedge clk);
    end
    check("rst_mid_rises", rcnt, 8);
    check("rst_mid_sclk_before", sclk, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ncs", ncs, 1);
    check("rst_mid_sclk", sclk, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_ready", bus.req_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready_after", bus.req_ready, 1);
    check("rst_mid_reg_kept", regs[0], 8'h66);

    check("waveform_rules", wave_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
